// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-path types and constants for the instruction prefetch queue.
package cpu_fetch_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_W    = 32;
   localparam logic [PC_W-1:0] PC_INC = 32'd4;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } fetch_entry_t;

   localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head reads as zero when empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !flush && (count != CNT_W'(DEPTH));
   assign do_pop  = pop && !flush && (count != '0);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetcher: credit-limited fetch requests, in-order response
// buffering, and redirect flush with stale-response dropping.
module instr_prefetch_queue
   import cpu_fetch_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    instr_pc,
   input  logic               instr_ready
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [PC_W-1:0]  fetch_pc;
   logic [PC_W-1:0]  fetch_pc_nxt;
   logic [PC_W-1:0]  resp_pc;
   logic [PC_W-1:0]  resp_pc_nxt;
   logic [PC_W-1:0]  redirect_aligned;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] outstanding_nxt;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] drop_cnt_nxt;
   logic [CNT_W:0]   credits_used;
   logic             grant;
   logic             resp_ok;
   logic             push;
   logic             pop;
   fetch_entry_t     push_entry;
   fetch_entry_t     head_entry;

   // Buffered plus in-flight fetches may never exceed the FIFO depth.
   assign credits_used = {1'b0, count} + {1'b0, outstanding};
   assign imem_req     = !reset && !redirect_valid &&
                         (credits_used < (CNT_W + 1)'(DEPTH));
   assign imem_addr    = fetch_pc;

   assign grant   = imem_req && imem_gnt;
   // A response with nothing outstanding is a protocol violation and ignored.
   assign resp_ok = imem_rvalid && (outstanding != '0);
   assign push    = resp_ok && (drop_cnt == '0) && !redirect_valid;
   assign pop     = instr_valid && instr_ready && !redirect_valid;

   assign redirect_aligned = redirect_pc & ~PC_W'(3);

   always_comb begin
      push_entry.instr = imem_rdata;
      push_entry.pc    = resp_pc;
   end

   // Next-state for fetch/response PCs and the credit/drop counters.
   always_comb begin
      fetch_pc_nxt    = fetch_pc;
      resp_pc_nxt     = resp_pc;
      outstanding_nxt = outstanding + CNT_W'(grant) - CNT_W'(resp_ok);
      drop_cnt_nxt    = drop_cnt;
      if (redirect_valid) begin
         fetch_pc_nxt = redirect_aligned;
         resp_pc_nxt  = redirect_aligned;
         drop_cnt_nxt = outstanding - CNT_W'(resp_ok);
      end else begin
         if (grant) fetch_pc_nxt = fetch_pc + PC_INC;
         if (push)  resp_pc_nxt  = resp_pc + PC_INC;
         if (resp_ok && (drop_cnt != '0)) drop_cnt_nxt = drop_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         fetch_pc    <= fetch_pc_nxt;
         resp_pc     <= resp_pc_nxt;
         outstanding <= outstanding_nxt;
         drop_cnt    <= drop_cnt_nxt;
      end
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .flush     (redirect_valid),
      .push_data (push_entry),
      .head      (head_entry),
      .count     (count)
   );

   assign instr_valid = (count != '0);
   assign instr       = head_entry.instr;
   assign instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with an in-order memory model.
module tb_instr_prefetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_miss = 0;
   int          cyc = 0;
   int          lat = 1;
   int          n_grants = 0;
   logic [31:0] last_gnt_addr = '0;
   logic        nxt_reset = 1'b1;
   logic        nxt_ready = 1'b0;
   logic        nxt_redir = 1'b0;
   logic [31:0] nxt_rpc = '0;
   logic        gnt_en = 1'b0;
   logic [31:0] pend_addr [$];
   int          pend_due  [$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs at negedge, model memory, observe before posedge.
   task automatic cycle();
      @(negedge clk);
      reset          = nxt_reset;
      instr_ready    = nxt_ready;
      redirect_valid = nxt_redir;
      redirect_pc    = nxt_rpc;
      imem_gnt       = gnt_en;
      if (nxt_reset) begin
         pend_addr.delete();
         pend_due.delete();
      end
      if (!nxt_reset && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = pend_addr.pop_front();
         void'(pend_due.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end
      #1;
      if (imem_req && imem_gnt) begin
         pend_addr.push_back(imem_addr);
         pend_due.push_back(cyc + lat);
         n_grants++;
         last_gnt_addr = imem_addr;
      end
      cyc++;
   endtask

   task automatic do_reset();
      nxt_reset = 1'b1;
      nxt_ready = 1'b0;
      nxt_redir = 1'b0;
      gnt_en    = 1'b0;
      cycle();
      cycle();
      nxt_reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

      // Reset state
      do_reset();
      check_val("rst_req",   32'(imem_req),    32'd0);
      check_val("rst_valid", 32'(instr_valid), 32'd0);
      check_val("rst_instr", instr,            32'd0);
      check_val("rst_pc",    instr_pc,         32'd0);
      check_val("rst_addr",  imem_addr,        32'd0);

      // 1: streaming at one-cycle memory latency
      gnt_en = 1'b1; lat = 1; nxt_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         check_val("t1_addr",  imem_addr,        32'(4 * k));
         check_val("t1_valid", 32'(instr_valid), 32'(k >= 2));
         if (k >= 2) begin
            check_val("t1_instr", instr,    32'(4 * (k - 2)));
            check_val("t1_pc",    instr_pc, 32'(4 * (k - 2)));
         end
      end

      // 2: backpressure fills the queue, then drain
      do_reset();
      gnt_en = 1'b1; lat = 1; nxt_ready = 1'b0; n_grants = 0;
      repeat (8) cycle();
      check_val("t2_grants",   32'(n_grants),    32'd4);
      check_val("t2_lastaddr", last_gnt_addr,    32'd12);
      check_val("t2_req_full", 32'(imem_req),    32'd0);
      check_val("t2_valid",    32'(instr_valid), 32'd1);
      nxt_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         check_val("t2_pop_pc",    instr_pc, 32'(4 * k));
         check_val("t2_pop_instr", instr,    32'(4 * k));
         if (k == 0) check_val("t2_req_hold", 32'(imem_req), 32'd0);
         if (k == 1) begin
            check_val("t2_next_gnt", last_gnt_addr, 32'd16);
            check_val("t2_ngrants",  32'(n_grants), 32'd5);
         end
      end

      // 3: redirect with two fetches in flight at latency 3
      do_reset();
      gnt_en = 1'b1; lat = 3; nxt_ready = 1'b0;
      cycle();
      cycle();
      gnt_en = 1'b0; nxt_redir = 1'b1; nxt_rpc = 32'h100;
      cycle();
      check_val("t3_req_redir", 32'(imem_req), 32'd0);
      nxt_redir = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cycle();
         check_val("t3_drop_valid", 32'(instr_valid), 32'd0);
         check_val("t3_addr",       imem_addr,        32'h100);
      end
      gnt_en = 1'b1;
      begin
         int waited = 0;
         bit seen = 0;
         for (int k = 0; k < 20 && !seen; k++) begin
            cycle();
            if (instr_valid) seen = 1; else waited++;
         end
         check_val("t3_seen",  32'(seen),   32'd1);
         check_val("t3_wait",  32'(waited), 32'd4);
         check_val("t3_pc",    instr_pc,    32'h100);
         check_val("t3_instr", instr,       32'h100);
      end

      // 4: grant withheld keeps the address stable
      do_reset();
      gnt_en = 1'b0; lat = 2; nxt_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         check_val("t4_req",  32'(imem_req), 32'd1);
         check_val("t4_addr", imem_addr,     32'd0);
      end
      gnt_en = 1'b1;
      cycle();
      gnt_en = 1'b0;
      cycle();
      check_val("t4_addr_adv", imem_addr, 32'd4);

      // 5: unaligned redirect coincident with the only response
      nxt_redir = 1'b1; nxt_rpc = 32'h103;
      cycle();
      check_val("t5_rvalid_seen", 32'(imem_rvalid), 32'd1);
      nxt_redir = 1'b0; gnt_en = 1'b1; lat = 1;
      cycle();
      check_val("t5_addr",   imem_addr,        32'h100);
      check_val("t5_valid0", 32'(instr_valid), 32'd0);
      cycle();
      check_val("t5_valid1", 32'(instr_valid), 32'd0);
      check_val("t5_addr2",  imem_addr,        32'h104);
      cycle();
      check_val("t5_valid2", 32'(instr_valid), 32'd1);
      check_val("t5_pc",     instr_pc,         32'h100);
      check_val("t5_instr",  instr,            32'h100);

      // 6: reset mid-stream with three entries buffered
      do_reset();
      gnt_en = 1'b1; lat = 1; nxt_ready = 1'b0;
      repeat (4) cycle();
      nxt_reset = 1'b1;
      cycle();
      check_val("t6_full_valid", 32'(instr_valid), 32'd1);
      check_val("t6_req_rst",    32'(imem_req),    32'd0);
      nxt_reset = 1'b0;
      cycle();
      check_val("t6_valid", 32'(instr_valid), 32'd0);
      check_val("t6_instr", instr,            32'd0);
      check_val("t6_pc",    instr_pc,         32'd0);
      check_val("t6_addr",  imem_addr,        32'd0);
      check_val("t6_req",   32'(imem_req),    32'd1);
      cycle();
      check_val("t6_addr2", imem_addr, 32'd4);
      cycle();
      check_val("t6_restart_valid", 32'(instr_valid), 32'd1);
      check_val("t6_restart_pc",    instr_pc,         32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
Upstream neighbour of the pipelined CPU's fetch stage. It issues word-aligned instruction fetches to instruction memory over a request/grant/response handshake and buffers the returned words with their PCs in a DEPTH-entry FIFO. It presents one instruction per cycle to the stage-0 decode logic. On a branch, jump or jr redirect it flushes its contents and discards stale in-flight responses.

Parameters:
DEPTH, 4, FIFO entries; also the maximum of (buffered + outstanding) fetches; power of 2, at least 2
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high; clears all state
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address; equals fetch_pc; low 2 bits always 0
imem_gnt  in  1  memory accepts the request this cycle
imem_rvalid  in  1  response word valid; responses return in order, at least 1 cycle after grant
imem_rdata  in  32  instruction word
redirect_valid  in  1  branch/jump taken; flush and refetch
redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
instr_valid  out  1  FIFO head valid
instr  out  32  FIFO head instruction word
instr_pc  out  32  PC of the FIFO head
instr_ready  in  1  decode consumes the head this cycle

Behaviour:
- State:
  - fetch_pc (32 bits)
  - resp_pc (32 bits)
  - count, outstanding, drop_cnt, each $clog2(DEPTH+1) bits
  - FIFO of {instr, pc} entries
- Reset (synchronous):
  - fetch_pc and resp_pc = RESET_PC; count, outstanding and drop_cnt = 0.
  - Outputs: imem_req = 0, imem_addr = RESET_PC, instr_valid = 0, instr = 0, instr_pc = 0.
  - The FIFO pointers clear.
- Request:
  - imem_req = !reset && !redirect_valid && (count + outstanding < DEPTH).
  - A grant is accepted when imem_req && imem_gnt. On a grant, fetch_pc += 4 (wraps mod 2^32) and outstanding += 1.
  - imem_addr holds steady while imem_req=1 and imem_gnt=0.
- Response:
  - Every imem_rvalid decrements outstanding.
  - If drop_cnt > 0, the word is discarded and drop_cnt -= 1.
  - Otherwise the word is pushed as {imem_rdata, resp_pc} and resp_pc += 4.
  - imem_rvalid with outstanding == 0 is a protocol violation: ignored, no state change.
- Output:
  - instr_valid = (count > 0); instr and instr_pc show the FIFO head (both 0 when empty).
  - A pop happens when instr_valid && instr_ready && !redirect_valid.
  - Latency: a word accepted on imem_rvalid in cycle N is visible at the head in cycle N+1 at the earliest. There is no bypass path.
- Simultaneous push and pop: count is unchanged and both succeed.
  - The credit rule guarantees count never exceeds DEPTH, so a push never overflows.
- Redirect (redirect_valid=1 in cycle N), effective at the next edge:
  - count = 0 and the FIFO pointers reset. A pop or grant in cycle N has no effect.
  - fetch_pc and resp_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt = outstanding minus (1 if imem_rvalid in cycle N). outstanding is updated normally.
  - A response arriving in cycle N is discarded.
  - A repeated redirect while drop_cnt > 0 recomputes drop_cnt by the same rule.
- Reset mid-operation wins over everything. Instruction memory shares the same reset, so no pre-reset responses return.
- Invariant: count + outstanding <= DEPTH, and drop_cnt <= outstanding.

Decomposition:
- Shared package cpu_fetch_pkg:
  - INSTR_W = 32
  - PC_W = 32
  - PC_INC = 32'd4
  - typedef fetch_entry_t = struct {instr, pc}
- One sub-module: sync_fifo (parameterised on width and depth; push, pop, flush, count, head; synchronous reset). Instantiate it with the width of fetch_entry_t.
- Request, credit and drop logic stays in instr_prefetch_queue.

Test Plan:
1. Reset, then imem_gnt=1, memory returns rdata=addr one cycle after each grant, instr_ready=1 -> imem_addr 0,4,8,...; instr_valid first high 2 cycles after the first grant; instr/instr_pc = 0/0, 4/4, 8/8, one per cycle.
2. Same stimulus with instr_ready=0 -> exactly 4 grants (addrs 0..12), then imem_req=0 with count=4. Raise instr_ready -> pops 0,4,8,12 in order; the next grant is at addr 16.
3. Memory at 3-cycle latency with 2 outstanding; redirect_valid for 1 cycle with redirect_pc=32'h100 -> the next 2 rvalids are discarded and instr_valid stays 0. The first head is instr_pc=32'h100 with rdata=32'h100.
4. imem_gnt=0 for 5 cycles with the FIFO not full -> imem_req=1 and imem_addr stable at the same value. Grant on cycle 6 -> addr advances by 4.
5. redirect_pc=32'h103, with imem_rvalid in the same cycle and outstanding=1 -> imem_addr=32'h100; the coincident response is discarded; drop_cnt=0 afterwards.
6. Assert reset mid-stream with count=3 -> next cycle instr_valid=0, instr=0, instr_pc=0, imem_addr=RESET_PC; fetching restarts from 0.
